// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//
// UART receive engine for the AHB-Lite UART. It sits between the
// asynchronous uart_rxd pin and the RX FIFO. It synchronises the pin and
// oversamples it on bclk ticks. Each frame is assembled and then committed to
// the FIFO as one registered write strobe, with parity, framing, break and
// overrun status pulses.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   -> each sample point takes the 2-of-3 majority of rxs at count
//                mid-1, mid and mid+1. The decision is made at mid+1.
//   undefined -> a single sample of rxs at count mid.
//   Frame timing and the commit cycle are the same in both builds.
//
// Parameters
//   DATA_W      maximum data bits per frame (wls selects DATA_W-3..DATA_W)
//   OSR_W       width of the oversample counter and the osr port
//   SYNC_STAGES flops in the uart_rxd synchroniser (>= 2)
//
// Ports
//   pclk            system clock
//   presetn         asynchronous active-low reset
//   bclk            oversample tick, one pclk wide
//   uart_rxd        asynchronous serial input
//   rx_en           receiver enable; low aborts any frame in flight
//   osr             oversample ratio minus 1 (legal 7..2^OSR_W-1)
//   wls             word length select, 0..3 -> DATA_W-3..DATA_W bits
//   pen/eps/sp      parity enable / even parity / stick parity
//   stb             0 = one stop bit, 1 = two stop bits
//   rx_full_status  RX FIFO full; a commit then raises s_overrun, not rx_wr
//   rx_data         last committed word, right-justified, zero-extended
//   rx_wr           FIFO write strobe
//   s_*             status pulses issued in the commit cycle
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int DATA_W      = 8,
    parameter int OSR_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              bclk,
    input  logic              uart_rxd,
    input  logic              rx_en,
    input  logic [OSR_W-1:0]  osr,
    input  logic [1:0]        wls,
    input  logic              pen,
    input  logic              eps,
    input  logic              sp,
    input  logic              stb,
    input  logic              rx_full_status,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_wr,
    output logic              s_parity_error,
    output logic              s_framing_error,
    output logic              s_break,
    output logic              s_overrun
);

    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser; it resets to the idle (mark) level.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rxd};
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t             r_state,  w_state_next;
    logic [OSR_W-1:0]   r_count,  w_count_next;
    logic [BIT_W-1:0]   r_bitcnt, w_bitcnt_next;
    logic [DATA_W-1:0]  r_shift,  w_shift_next;
    logic               r_par,    w_par_next;
    logic               r_ferr,   w_ferr_next;
    logic               r_zero,   w_zero_next;   // every bit so far sampled 0
    logic               r_stop2,  w_stop2_next;  // receiving second stop bit
    logic               w_commit;

    logic [OSR_W-1:0]   w_mid;
    logic               w_bit_end;
    logic               w_sample_tick;
    logic               w_sample_val;
    logic [BIT_W-1:0]   w_last_bit;
    logic               w_par_bad;

    assign w_mid      = osr >> 1;
    assign w_bit_end  = bclk && (r_count == osr);
    assign w_last_bit = BIT_W'(DATA_W - 4) + BIT_W'(wls);

`ifdef UART_RX_MAJORITY_EN
    // Capture rxs at mid-1 and mid. The vote is taken at mid+1, so the
    // decision always lands one tick after the single-sample build.
    logic [OSR_W-1:0] w_mid_m1;
    logic [OSR_W-1:0] w_mid_p1;
    logic [1:0]       r_maj;

    assign w_mid_m1 = w_mid - OSR_W'(1);
    assign w_mid_p1 = w_mid + OSR_W'(1);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_maj <= 2'b11;
        end else if (bclk) begin
            if (r_count == w_mid_m1) r_maj[0] <= w_rxs;
            if (r_count == w_mid)    r_maj[1] <= w_rxs;
        end
    end

    assign w_sample_tick = bclk && (r_count == w_mid_p1);
    assign w_sample_val  = (r_maj[0] & r_maj[1]) | (r_maj[0] & w_rxs) |
                           (r_maj[1] & w_rxs);
`else
    assign w_sample_tick = bclk && (r_count == w_mid);
    assign w_sample_val  = w_rxs;
`endif

    // Stick parity fixes the parity bit at ~eps. Otherwise the XOR of the
    // data and parity bits must equal ~eps. Unused upper data bits are
    // zero, so they do not affect the XOR.
    assign w_par_bad = sp ? (r_par == eps) : ((^r_shift ^ r_par) == eps);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_ferr   <= 1'b0;
            r_zero   <= 1'b0;
            r_stop2  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_bitcnt <= w_bitcnt_next;
            r_shift  <= w_shift_next;
            r_par    <= w_par_next;
            r_ferr   <= w_ferr_next;
            r_zero   <= w_zero_next;
            r_stop2  <= w_stop2_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_bitcnt_next = r_bitcnt;
        w_shift_next  = r_shift;
        w_par_next    = r_par;
        w_ferr_next   = r_ferr;
        w_zero_next   = r_zero;
        w_stop2_next  = r_stop2;
        w_commit      = 1'b0;

        if (bclk) begin
            w_count_next = (r_count == osr) ? '0 : r_count + OSR_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                w_count_next = '0;
                if (bclk && !w_rxs) begin
                    // The detecting tick is tick 0 of the start bit, so the
                    // counter resumes at 1 and the bit spans exactly osr+1 ticks.
                    w_state_next  = S_START;
                    w_count_next  = OSR_W'(1);
                    w_bitcnt_next = '0;
                    w_shift_next  = '0;
                    w_par_next    = 1'b0;
                    w_ferr_next   = 1'b0;
                    w_zero_next   = 1'b1;
                    w_stop2_next  = 1'b0;
                end
            end

            S_START: begin
                if (w_sample_tick && w_sample_val) begin
                    w_state_next = S_IDLE;      // glitch, not a real start bit
                    w_count_next = '0;
                end else if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end

            S_DATA: begin
                if (w_sample_tick) begin
                    w_shift_next[r_bitcnt] = w_sample_val;
                    if (w_sample_val) w_zero_next = 1'b0;
                end
                if (w_bit_end) begin
                    if (r_bitcnt == w_last_bit) begin
                        w_bitcnt_next = '0;
                        w_state_next  = pen ? S_PARITY : S_STOP;
                    end else begin
                        w_bitcnt_next = r_bitcnt + BIT_W'(1);
                    end
                end
            end

            S_PARITY: begin
                if (w_sample_tick) begin
                    w_par_next = w_sample_val;
                    if (w_sample_val) w_zero_next = 1'b0;
                end
                if (w_bit_end) w_state_next = S_STOP;
            end

            S_STOP: begin
                if (w_sample_tick) begin
                    if (!w_sample_val) w_ferr_next = 1'b1;
                    // Only the first stop bit takes part in break detection.
                    if (!r_stop2 && w_sample_val) w_zero_next = 1'b0;
                end
                if (w_bit_end) begin
                    if (stb && !r_stop2) begin
                        w_stop2_next = 1'b1;
                    end else begin
                        w_commit     = 1'b1;
                        w_state_next = r_zero ? S_BRK_WAIT : S_IDLE;
                    end
                end
            end

            S_BRK_WAIT: begin
                w_count_next = '0;
                if (bclk && w_rxs) w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
                w_count_next = '0;
            end
        endcase

        // Dropping rx_en discards the frame in flight without any strobes.
        if (!rx_en) begin
            w_state_next  = S_IDLE;
            w_count_next  = '0;
            w_bitcnt_next = '0;
            w_stop2_next  = 1'b0;
            w_commit      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Commit stage: registered, so it is visible one pclk after the tick.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_wr;
    logic              r_perr;
    logic              r_ferr_out;
    logic              r_brk;
    logic              r_ovr;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rx_data  <= '0;
            r_rx_wr    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr_out <= 1'b0;
            r_brk      <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_rx_wr    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr_out <= 1'b0;
            r_brk      <= 1'b0;
            r_ovr      <= 1'b0;
            if (w_commit) begin
                r_rx_data  <= r_shift;
                r_rx_wr    <= !rx_full_status;
                r_ovr      <= rx_full_status;
                r_brk      <= r_zero;
                r_ferr_out <= r_ferr | r_zero;
                r_perr     <= pen && !r_zero && w_par_bad;
            end
        end
    end

    assign rx_data         = r_rx_data;
    assign rx_wr           = r_rx_wr;
    assign s_parity_error  = r_perr;
    assign s_framing_error = r_ferr_out;
    assign s_break         = r_brk;
    assign s_overrun       = r_ovr;

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//
// Directed testbench for uart_rx_core (DATA_W=8, OSR_W=4, SYNC_STAGES=2).
// bclk fires once every 4 pclk. Serial bits are driven just after a tick,
// so the synchroniser settles well before the next tick. Strobes are
// counted by a monitor, and each test compares the change in the counts
// with hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       bclk = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_en = 1'b0;
    logic [3:0] osr = 4'd15;
    logic [1:0] wls = 2'd3;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sp = 1'b0;
    logic       stb = 1'b0;
    logic       rx_full_status = 1'b0;
    logic [7:0] rx_data;
    logic       rx_wr;
    logic       s_parity_error;
    logic       s_framing_error;
    logic       s_break;
    logic       s_overrun;

    uart_rx_core #(
        .DATA_W      (8),
        .OSR_W       (4),
        .SYNC_STAGES (2)
    ) dut (
        .pclk            (pclk),
        .presetn         (presetn),
        .bclk            (bclk),
        .uart_rxd        (uart_rxd),
        .rx_en           (rx_en),
        .osr             (osr),
        .wls             (wls),
        .pen             (pen),
        .eps             (eps),
        .sp              (sp),
        .stb             (stb),
        .rx_full_status  (rx_full_status),
        .rx_data         (rx_data),
        .rx_wr           (rx_wr),
        .s_parity_error  (s_parity_error),
        .s_framing_error (s_framing_error),
        .s_break         (s_break),
        .s_overrun       (s_overrun)
    );

    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;

    int c_wr = 0, c_pe = 0, c_fe = 0, c_brk = 0, c_ovr = 0;
    int b_wr = 0, b_pe = 0, b_fe = 0, b_brk = 0, b_ovr = 0;
    int tick_no = 0;
    int wr_tick = -1;
    int frame_end = 0;

    // Count every pclk that carries a strobe (sampled mid-cycle).
    always @(negedge pclk) begin
        if (rx_wr)           c_wr++;
        if (s_parity_error)  c_pe++;
        if (s_framing_error) c_fe++;
        if (s_break)         c_brk++;
        if (s_overrun)       c_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe counts since the last snap, packed as 0xWPFBO in hex nibbles.
    task automatic check_pulses(input string tag, input logic [31:0] exp);
        logic [31:0] got;
        got = ((c_wr - b_wr) << 16) | ((c_pe - b_pe) << 12) | ((c_fe - b_fe) << 8) |
              ((c_brk - b_brk) << 4) | (c_ovr - b_ovr);
        check(tag, got, exp);
    endtask

    task automatic snap();
        b_wr = c_wr; b_pe = c_pe; b_fe = c_fe; b_brk = c_brk; b_ovr = c_ovr;
        wr_tick = -1;
    endtask

    // One bclk tick: three quiet pclks, then one with bclk high. Sampling on
    // the following negedge shows what was registered on that tick's edge.
    task automatic tick();
        repeat (3) @(negedge pclk);
        bclk = 1'b1;
        @(negedge pclk);
        bclk = 1'b0;
        tick_no++;
        if (rx_wr) wr_tick = tick_no;
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic use_par,
                              input logic pbit, input logic [1:0] stops, input int nstop);
        int tpb;
        tpb = int'(osr) + 1;
        uart_rxd = 1'b0;
        repeat (tpb) tick();
        for (int i = 0; i < nbits; i++) begin
            uart_rxd = data[i];
            repeat (tpb) tick();
        end
        if (use_par) begin
            uart_rxd = pbit;
            repeat (tpb) tick();
        end
        for (int i = 0; i < nstop; i++) begin
            uart_rxd = stops[i];
            repeat (tpb) tick();
        end
        frame_end = tick_no;
        uart_rxd = 1'b1;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(negedge pclk);
        check("rst_data", rx_data, 8'h00);
        check("rst_pulses", {rx_wr, s_parity_error, s_framing_error, s_break, s_overrun}, 5'b0);
        presetn = 1'b1;
        rx_en = 1'b1;
        repeat (3) tick();

        // ---------------- 0xA5, 8N1, x16 ----------------
        snap();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 2'b11, 1);
        repeat (2) tick();
        $display("frame 0xA5 8N1: rx_data=%02h", rx_data);
        check("a5_data", rx_data, 8'hA5);
        check_pulses("a5_pulses", 32'h10000);
        check("a5_wr_tick", wr_tick, frame_end);

        // ---------------- back-to-back frames ----------------
        snap();
        send_frame(8'h12, 8, 1'b0, 1'b0, 2'b11, 1);
        send_frame(8'h34, 8, 1'b0, 1'b0, 2'b11, 1);
        repeat (2) tick();
        $display("frames 0x12,0x34 back-to-back: rx_data=%02h", rx_data);
        check("b2b_data", rx_data, 8'h34);
        check_pulses("b2b_pulses", 32'h20000);

        // ---------------- parity, x13, 5 data bits ----------------
        osr = 4'd12; wls = 2'd0; pen = 1'b1; eps = 1'b1; sp = 1'b0;
        repeat (2) tick();
        snap();
        send_frame(8'h13, 5, 1'b1, 1'b0, 2'b11, 1);   // 3 ones + 0 -> odd, even wanted
        repeat (2) tick();
        $display("frame 0x13 even par=0: rx_data=%02h", rx_data);
        check("pe_bad_data", rx_data, 8'h13);
        check_pulses("pe_bad_pulses", 32'h11000);
        check("pe_bad_wr_tick", wr_tick, frame_end);

        snap();
        send_frame(8'h13, 5, 1'b1, 1'b1, 2'b11, 1);
        repeat (2) tick();
        $display("frame 0x13 even par=1: rx_data=%02h", rx_data);
        check_pulses("pe_good_pulses", 32'h10000);

        eps = 1'b0;                                      // odd parity: par 0 is right
        snap();
        send_frame(8'h13, 5, 1'b1, 1'b0, 2'b11, 1);
        repeat (2) tick();
        $display("frame 0x13 odd par=0");
        check_pulses("odd_pulses", 32'h10000);

        eps = 1'b1; sp = 1'b1;                           // stick: bit must be ~eps = 0
        snap();
        send_frame(8'h13, 5, 1'b1, 1'b1, 2'b11, 1);
        repeat (2) tick();
        $display("frame 0x13 stick par=1");
        check_pulses("stick_bad_pulses", 32'h11000);
        snap();
        send_frame(8'h13, 5, 1'b1, 1'b0, 2'b11, 1);
        repeat (2) tick();
        $display("frame 0x13 stick par=0");
        check_pulses("stick_good_pulses", 32'h10000);

        osr = 4'd15; wls = 2'd3; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        repeat (2) tick();

        // ---------------- start glitch ----------------
        snap();
        uart_rxd = 1'b0;
        repeat (4) tick();
        uart_rxd = 1'b1;
        repeat (40) tick();
        $display("glitch 4 ticks low");
        check_pulses("glitch_pulses", 32'h00000);
        check("glitch_hold", rx_data, 8'h13);

        // ---------------- framing error ----------------
        snap();
        send_frame(8'h55, 8, 1'b0, 1'b0, 2'b00, 1);
        repeat (2) tick();
        $display("frame 0x55 stop=0: rx_data=%02h", rx_data);
        check("fe_data", rx_data, 8'h55);
        check_pulses("fe_pulses", 32'h10100);

        // ---------------- two stop bits ----------------
        stb = 1'b1;
        snap();
        send_frame(8'hC3, 8, 1'b0, 1'b0, 2'b11, 2);
        repeat (2) tick();
        $display("frame 0xC3 8N2: rx_data=%02h", rx_data);
        check("stb_data", rx_data, 8'hC3);
        check_pulses("stb_pulses", 32'h10000);
        check("stb_wr_tick", wr_tick, frame_end);
        snap();
        send_frame(8'h0F, 8, 1'b0, 1'b0, 2'b01, 2);     // second stop bit low
        repeat (2) tick();
        $display("frame 0x0F 8N2 stop2=0: rx_data=%02h", rx_data);
        check_pulses("stb_fe_pulses", 32'h10100);
        stb = 1'b0;

        // ---------------- break ----------------
        snap();
        uart_rxd = 1'b0;
        repeat (30 * 16) tick();
        uart_rxd = 1'b1;
        repeat (4) tick();
        $display("break 3 frame times: rx_data=%02h", rx_data);
        check("brk_data", rx_data, 8'h00);
        check_pulses("brk_pulses", 32'h10110);

        // ---------------- overrun ----------------
        rx_full_status = 1'b1;
        snap();
        send_frame(8'h3C, 8, 1'b0, 1'b0, 2'b11, 1);
        repeat (2) tick();
        rx_full_status = 1'b0;
        $display("frame 0x3C fifo full: rx_data=%02h", rx_data);
        check("ovr_data", rx_data, 8'h3C);
        check_pulses("ovr_pulses", 32'h00001);

        // ---------------- rx_en abort ----------------
        snap();
        uart_rxd = 1'b0;
        repeat (16) tick();
        uart_rxd = 1'b1;
        repeat (4 * 16 + 8) tick();                      // bits 0..3, half of bit 4
        rx_en = 1'b0;
        repeat (8 + 3 * 16 + 16) tick();                 // rest of 0xFF and stop
        rx_en = 1'b1;
        repeat (4) tick();
        $display("abort 0xFF at bit 4: rx_data=%02h", rx_data);
        check_pulses("abort_pulses", 32'h00000);
        check("abort_hold", rx_data, 8'h3C);
        snap();
        send_frame(8'h81, 8, 1'b0, 1'b0, 2'b11, 1);
        repeat (2) tick();
        $display("frame 0x81 after abort: rx_data=%02h", rx_data);
        check("reen_data", rx_data, 8'h81);
        check_pulses("reen_pulses", 32'h10000);

        // ---------------- reset mid-frame ----------------
        uart_rxd = 1'b0;
        repeat (16 + 10) tick();
        presetn = 1'b0;
        #1;
        $display("presetn mid-frame: rx_data=%02h", rx_data);
        check("mrst_data", rx_data, 8'h00);
        check("mrst_pulses", {rx_wr, s_parity_error, s_framing_error, s_break, s_overrun}, 5'b0);
        repeat (2) @(negedge pclk);
        uart_rxd = 1'b1;
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        repeat (3) tick();
        snap();
        send_frame(8'h5A, 8, 1'b0, 1'b0, 2'b11, 1);
        repeat (2) tick();
        $display("frame 0x5A after reset: rx_data=%02h", rx_data);
        check("post_rst_data", rx_data, 8'h5A);
        check_pulses("post_rst_pulses", 32'h10000);
        check("post_rst_wr_tick", wr_tick, frame_end);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
